uart_tx: RTL and testbench

UART transmitter serializing 9-bit words onto a single line: 1 start bit (low), 9 data bits MSB first, 1 stop bit (high), no parity. It is the transmit end of the link whose receive end is `uart_rx`. Bit order and frame format match `uart_rx`, so a loopback of `tx` into `rx` returns the same word. A one-word holding register allows back-to-back frames with no idle gap.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_baud_gen.sv | 26 ++
 rtl/uart_tx.sv | 117 +++++++++++
 tb/tb_uart_tx.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Types and link parameters shared by the uart_tx / uart_rx pair.
package uart_pkg;

  localparam int UART_CLK_HZ    = 25_000_000;
  localparam int UART_BAUD_RATE = 9600;
  localparam int UART_DATA_BITS = 9;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer for uart_tx: ticks once every DIVISOR clocks while enabled.
module uart_tx_baud_gen #(
  parameter int DIVISOR = 2604
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    tick    = enable && (count_q == CW'(DIVISOR - 1));
    count_d = '0;
    if (enable && !tick) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits MSB first, stop bit, no parity.
// A one-word holding register lets the next frame start straight out of STOP.
//
// state | meaning
// IDLE  | line high, waiting for a held word
// START | driving the start bit (low)
// DATA  | shifting data bits out, MSB first
// STOP  | driving the stop bit (high)
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = UART_CLK_HZ,
  parameter int BAUD_RATE = UART_BAUD_RATE,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 send,
  output logic                 ready,
  output logic                 busy,
  output logic                 tx
);

  localparam int DIVISOR = CLK_HZ / BAUD_RATE;
  localparam int BCW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("uart_tx: CLK_HZ / BAUD_RATE must be at least 2");
  end

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 bit_tick, accept, load;

  uart_tx_baud_gen #(.DIVISOR(DIVISOR)) u_baud_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (state_q != IDLE),
    .tick    (bit_tick)
  );

  // A drain only happens while hold_valid_q is set, so it never meets an accept.
  assign accept = send && !hold_valid_q;
  assign load   = hold_valid_q && ((state_q == IDLE) || ((state_q == STOP) && bit_tick));

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    bit_cnt_d    = bit_cnt_q;
    tx_d         = tx_q;

    if (accept) begin
      hold_d       = data;
      hold_valid_d = 1'b1;
    end

    if (load) begin
      state_d      = START;
      shift_d      = hold_q;
      hold_valid_d = 1'b0;
      tx_d         = 1'b0;
    end else begin
      case (state_q)
        START: if (bit_tick) begin
          state_d   = DATA;
          tx_d      = shift_q[DATA_BITS-1];
          bit_cnt_d = '0;
        end
        DATA: if (bit_tick) begin
          if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = shift_q << 1;
            tx_d      = shift_d[DATA_BITS-1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        STOP: if (bit_tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
    end
  end

  assign ready = !hold_valid_q;
  assign busy  = (state_q != IDLE) || hold_valid_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: line-level timing model plus a sampling receiver model.
module tb_uart_tx;

  localparam int DIV   = 16;
  localparam int NB    = 9;
  localparam int FRAME = 11 * DIV;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          send    = 1'b0;
  logic [NB-1:0] data    = '0;
  logic          ready, busy, tx;

  uart_tx #(.CLK_HZ(16), .BAUD_RATE(1), .DATA_BITS(NB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .data    (data),
    .send    (send),
    .ready   (ready),
    .busy    (busy),
    .tx      (tx)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Model: frames on the line as (start edge, word); edges counted since reset release.
  int            cyc = 0;
  int            hold_until = 0;
  int            frame_end = 0;
  int            fr_start[$];
  logic [NB-1:0] fr_word[$];
  logic [NB-1:0] rx_exp[$];
  int            n_accepted = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_until = 0;
      frame_end  = 0;
      fr_start.delete();
      fr_word.delete();
      rx_exp.delete();
    end else begin
      int s;
      cyc++;
      if (send && (cyc - 1 >= hold_until)) begin
        s = (cyc >= frame_end) ? cyc + 1 : frame_end;
        hold_until = s;
        frame_end  = s + FRAME;
        fr_start.push_back(s);
        fr_word.push_back(data);
        rx_exp.push_back(data);
        n_accepted++;
      end
    end
  end

  logic          rx_act = 1'b0;
  int            rx_cnt = 0;
  logic [NB-1:0] rx_word = '0;

  always @(negedge clock) begin
    logic          exp_tx;
    logic [NB-1:0] w;
    int            idx;
    exp_tx = 1'b1;
    foreach (fr_start[i]) begin
      if (cyc >= fr_start[i] && cyc < fr_start[i] + FRAME) begin
        idx = (cyc - fr_start[i]) / DIV;
        w   = fr_word[i];
        if (idx == 0)       exp_tx = 1'b0;
        else if (idx == 10) exp_tx = 1'b1;
        else                exp_tx = w[NB-idx];
      end
    end
    check_val("tx", tx, exp_tx);
    check_val("ready", ready, cyc >= hold_until);
    check_val("busy", busy, cyc < frame_end);

    if (!reset_n) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx == 1'b0) begin
        rx_act  = 1'b1;
        rx_cnt  = 0;
        rx_word = '0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt > DIV && rx_cnt < 10 * DIV && rx_cnt % DIV == DIV / 2)
        rx_word = {rx_word[NB-2:0], tx};
      if (rx_cnt == 10 * DIV + DIV / 2) begin
        check_val("rx_stop", tx, 1);
        if (rx_exp.size() > 0) check_val("rx_word", rx_word, rx_exp.pop_front());
        else                   check_val("rx_unexpected", rx_exp.size(), 1);
        rx_act = 1'b0;
      end
    end
  end

  task automatic send_word(input logic [NB-1:0] w);
    @(negedge clock);
    send = 1'b1;
    data = w;
    @(negedge clock);
    send = 1'b0;
  endtask

  task automatic wait_clocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int acc_before;
    wait_clocks(5);
    reset_n = 1'b1;
    wait_clocks(100);

    send_word(9'h1A5);
    wait_clocks(200);

    send_word(9'h0FF);
    wait_clocks(40);
    send_word(9'h100);
    wait_clocks(30);
    acc_before = n_accepted;
    send_word(9'h055);
    check_val("ignored_send", n_accepted, acc_before);
    wait_clocks(400);

    send_word(9'h0AA);
    repeat (88) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check_val("rst_tx", tx, 1);
    check_val("rst_ready", ready, 1);
    check_val("rst_busy", busy, 0);
    wait_clocks(3);
    reset_n = 1'b1;
    wait_clocks(300);

    send_word(9'h000);
    wait_clocks(10);
    send_word(9'h1FF);
    wait_clocks(200);
    send_word(9'h12B);
    wait_clocks(400);

    for (int i = 0; i < 30; i++) begin
      send_word(NB'($urandom_range(511, 0)));
      wait_clocks($urandom_range(250, 0));
    end
    wait_clocks(2 * FRAME + 20);

    check_val("rx_pending", rx_exp.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
